// File: rtl/sccb_config.sv
// Power-on SCCB/I2C configuration master: writes a 12-entry {reg,value} ROM to the HDMI transmitter.
// Latency: STARTUP_DELAY + 12*117*CLK_DIV clocks from reset release to done; bus outputs lag state by one clock.
// Backpressure: none; the slave ACK is don't-care (a NACK only sets sticky ack_err, no stall or retry).
module sccb_config #(
  parameter int         CLK_DIV       = 250,
  parameter int         STARTUP_DELAY = 200_000,
  parameter logic [7:0] DEV_ADDR      = 8'h72
) (
  input  logic        clk,
  input  logic        rst,
  output logic        sccb_sclk,
  inout  wire         sccb_data,
  output logic [15:0] LUT_DATA_r,
  output logic        done,
  output logic        ack_err
);

  localparam int QW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int DW = (STARTUP_DELAY > 1) ? $clog2(STARTUP_DELAY + 1) : 1;

  localparam logic [2:0] ST_WAIT  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_BITS  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  logic [2:0]    state;
  logic [QW-1:0] qcnt;
  logic [1:0]    phase;
  logic [4:0]    bitcnt;
  logic [3:0]    idx;
  logic [DW-1:0] dly;
  logic [15:0]   rom_entry;
  logic [26:0]   frame;
  logic          q_wrap;
  logic          is_ack;
  logic          sda_in;
  logic          scl_c;
  logic          oe_c;
  logic          scl_r;
  logic          sda_oe;

  assign q_wrap = (qcnt == QW'(CLK_DIV - 1));
  assign is_ack = (bitcnt == 5'd8) || (bitcnt == 5'd17) || (bitcnt == 5'd26);
  assign sda_in = sccb_data;

  // The 27 bit slots of one write, MSB first; a 1 in an ACK position means "release SDA".
  assign frame = {DEV_ADDR, 1'b1, LUT_DATA_r[15:8], 1'b1, LUT_DATA_r[7:0], 1'b1};

  // Register ROM, indexed by the current entry.
  always_comb begin
    rom_entry = 16'h4110;
    case (idx)
      4'd0:    rom_entry = 16'h4110;
      4'd1:    rom_entry = 16'h9803;
      4'd2:    rom_entry = 16'h9AE0;
      4'd3:    rom_entry = 16'h9C30;
      4'd4:    rom_entry = 16'h9D61;
      4'd5:    rom_entry = 16'hA2A4;
      4'd6:    rom_entry = 16'hA3A4;
      4'd7:    rom_entry = 16'hE0D0;
      4'd8:    rom_entry = 16'hF900;
      4'd9:    rom_entry = 16'h1500;
      4'd10:   rom_entry = 16'h1630;
      4'd11:   rom_entry = 16'hAF06;
      default: rom_entry = 16'h4110;
    endcase
  end

  // Bus levels implied by the current state and quarter phase; oe_c=1 pulls SDA low.
  always_comb begin
    scl_c = 1'b1;
    oe_c  = 1'b0;
    case (state)
      ST_START: begin
        oe_c  = 1'b1;
        scl_c = (phase == 2'd0);
      end
      ST_BITS: begin
        scl_c = (phase == 2'd1) || (phase == 2'd2);
        oe_c  = ~frame[5'd26 - bitcnt];
      end
      ST_STOP: begin
        scl_c = (phase != 2'd0);
        oe_c  = (phase != 2'd2);
      end
      default: begin
        scl_c = 1'b1;
        oe_c  = 1'b0;
      end
    endcase
  end

  // Sequencer: start-up delay, quarter-period timing, bit/entry stepping and ACK sampling.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_WAIT;
      qcnt    <= '0;
      phase   <= 2'd0;
      bitcnt  <= 5'd0;
      idx     <= 4'd0;
      dly     <= '0;
      done    <= 1'b0;
      ack_err <= 1'b0;
    end else begin
      if (state != ST_WAIT && state != ST_DONE)
        qcnt <= q_wrap ? '0 : qcnt + 1'b1;
      case (state)
        ST_WAIT: begin
          if (dly == DW'(STARTUP_DELAY - 1)) begin
            state <= ST_START;
            idx   <= 4'd0;
            phase <= 2'd0;
            qcnt  <= '0;
          end else begin
            dly <= dly + 1'b1;
          end
        end
        ST_START: begin
          if (q_wrap) begin
            if (phase == 2'd1) begin
              state  <= ST_BITS;
              phase  <= 2'd0;
              bitcnt <= 5'd0;
            end else begin
              phase <= phase + 1'b1;
            end
          end
        end
        ST_BITS: begin
          if (q_wrap) begin
            phase <= phase + 1'b1;
            // Middle of SCL high: a released (high) ACK slot is a NACK.
            if (phase == 2'd1 && is_ack && sda_in)
              ack_err <= 1'b1;
            if (phase == 2'd3) begin
              if (bitcnt == 5'd26) begin
                state  <= ST_STOP;
                bitcnt <= 5'd0;
              end else begin
                bitcnt <= bitcnt + 1'b1;
              end
            end
          end
        end
        ST_STOP: begin
          if (q_wrap) begin
            if (phase == 2'd2) begin
              state <= ST_GAP;
              phase <= 2'd0;
            end else begin
              phase <= phase + 1'b1;
            end
          end
        end
        ST_GAP: begin
          if (q_wrap) begin
            phase <= phase + 1'b1;
            if (phase == 2'd3) begin
              if (idx == 4'd11) begin
                state <= ST_DONE;
                done  <= 1'b1;
              end else begin
                idx   <= idx + 1'b1;
                state <= ST_START;
              end
            end
          end
        end
        ST_DONE: begin
          state <= ST_DONE;
        end
        default: begin
          state <= ST_WAIT;
        end
      endcase
    end
  end

  // Registered bus drivers so SCL/SDA never glitch on decode transitions.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_r  <= 1'b1;
      sda_oe <= 1'b0;
    end else begin
      scl_r  <= scl_c;
      sda_oe <= oe_c;
    end
  end

  // Current ROM entry, one clock behind the index.
  always_ff @(posedge clk) begin
    if (rst)
      LUT_DATA_r <= 16'h4110;
    else
      LUT_DATA_r <= rom_entry;
  end

  assign sccb_sclk = scl_r;
  assign sccb_data = sda_oe ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_sccb_config.sv
// Testbench for sccb_config: bus decoder + ACKing slave model with randomized NACK plans and resets.
// Latency: checks start delay, 468-clock transactions, done timing and SCL high time.
// Backpressure: the slave may NACK any slot; the sequence must continue regardless.
module tb_sccb_config;
  localparam int C   = 4;
  localparam int D   = 20;
  localparam int TXN = 117 * C;
  localparam int T   = D + 12 * TXN;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sccb_sclk;
  wire         sda_bus;
  logic [15:0] lut;
  logic        done;
  logic        ack_err;
  logic        slave_drv = 1'b0;

  pullup (sda_bus);
  assign sda_bus = slave_drv ? 1'b0 : 1'bz;

  sccb_config #(.CLK_DIV(C), .STARTUP_DELAY(D), .DEV_ADDR(8'h72)) dut (
    .clk(clk), .rst(rst), .sccb_sclk(sccb_sclk), .sccb_data(sda_bus),
    .LUT_DATA_r(lut), .done(done), .ack_err(ack_err)
  );

  always #5 clk = ~clk;

  logic [15:0] rom [12] = '{16'h4110, 16'h9803, 16'h9AE0, 16'h9C30, 16'h9D61, 16'hA2A4,
                            16'hA3A4, 16'hE0D0, 16'hF900, 16'h1500, 16'h1630, 16'hAF06};
  logic [2:0]  plan [12];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Bus decoder / slave / per-cycle model state
  int          rcyc, bcnt, txn, viol, rise_t, first_edge, first_start, last_start, last_interval, done_cyc, slot;
  bit          in_frame, err_rise, err_must;
  logic        prev_scl, prev_sda, cs, cd;
  logic [26:0] shreg;

  // Single compare process: decodes the bus, plays the slave and checks outputs every cycle.
  always @(negedge clk) begin
    cs = sccb_sclk;
    cd = sda_bus;
    if (rst) begin
      rcyc = 0; bcnt = 0; txn = 0; viol = 0; rise_t = -1; first_edge = -1;
      first_start = -1; last_start = -1; last_interval = -1; done_cyc = -1;
      in_frame = 0; err_rise = 0; err_must = 0; slave_drv = 1'b0; shreg = '0;
    end else begin
      rcyc++;
      if (prev_scl !== cs && first_edge < 0) first_edge = rcyc;
      // SDA changing while SCL stays high: only a START from idle or a STOP after 27 bits is legal.
      if (prev_scl === 1'b1 && cs === 1'b1 && prev_sda !== cd) begin
        if (cd === 1'b0) begin
          if (in_frame) viol++;
          in_frame = 1; bcnt = 0;
          if (first_start < 0) first_start = rcyc;
          if (last_start >= 0) begin
            last_interval = rcyc - last_start;
            chk("txn_interval", last_interval, TXN);
          end
          last_start = rcyc;
        end else begin
          if (!in_frame || bcnt != 27) viol++;
          else if (txn < 12) begin
            chk("txn_bytes", {shreg[26:19], shreg[17:10], shreg[8:1]}, {8'h72, rom[txn]});
            chk("txn_ack_bits", {shreg[18], shreg[9], shreg[0]}, plan[txn]);
            txn++;
          end else begin
            viol++;
          end
          in_frame = 0;
        end
      end
      if (prev_scl === 1'b0 && cs === 1'b1 && in_frame && bcnt < 27) begin
        if (bcnt == 0) begin
          if (txn < 12) chk("lut_entry", lut, rom[txn]);
          else viol++;
        end
        if ((bcnt == 8 || bcnt == 17 || bcnt == 26) && cd === 1'b1) err_rise = 1;
        shreg = {shreg[25:0], cd};
        rise_t = rcyc;
        bcnt++;
      end
      if (prev_scl === 1'b1 && cs === 1'b0 && in_frame) begin
        if (rise_t >= 0) begin
          chk("scl_high_time", rcyc - rise_t, 2 * C);
          rise_t = -1;
        end
        if (err_rise) err_must = 1;
        if ((bcnt == 8 || bcnt == 17 || bcnt == 26) && txn < 12) begin
          slot = (bcnt - 8) / 9;
          slave_drv = !plan[txn][2 - slot];
        end else begin
          slave_drv = 1'b0;
        end
      end
      if (err_must) chk("ack_err_set", ack_err, 1);
      else if (!err_rise) chk("ack_err_clear", ack_err, 0);
      if (done === 1'b1 && done_cyc < 0) done_cyc = rcyc;
      if (rcyc < T - 2) chk("done_early", done, 0);
      else if (rcyc > T + 2) begin
        chk("done_late", done, 1);
        chk("idle_bus", {lut, cs, cd}, {16'hAF06, 2'b11});
      end
    end
    prev_scl = cs;
    prev_sda = cd;
  end

  task automatic release_rst();
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic assert_rst(input int n);
    @(posedge clk); #1 rst = 1'b1;
    repeat (n) @(posedge clk);
  endtask

  task automatic wait_done();
    for (int i = 0; i < T + 200 && done !== 1'b1; i++) @(negedge clk);
    chk("done_timeout", done, 1);
    @(posedge clk); #1;
  endtask

  task automatic run_end(input logic exp_err);
    chk("txn_count", txn, 12);
    chk("bus_violations", viol, 0);
    chk("done_final", done, 1);
    chk("ack_err_final", ack_err, exp_err);
    chk("lut_final", lut, 16'hAF06);
    chk("done_time", (done_cyc >= T - 2 && done_cyc <= T + 2), 1);
    chk("done_time_literal", (done_cyc >= 5634 && done_cyc <= 5638), 1);
    chk("txn_clocks_literal", last_interval, 468);
    chk("no_early_scl_edge", (first_edge >= D), 1);
    chk("first_start_time", (first_start >= D && first_start <= D + 3), 1);
  endtask

  task automatic mid_reset(input int tt, input int lo, input int hi);
    for (int i = 0; i < T + 200 && !(txn == tt && in_frame && bcnt >= lo && bcnt <= hi); i++)
      @(posedge clk);
    chk("mid_reset_reached", (txn == tt && in_frame && bcnt >= lo && bcnt <= hi), 1);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mrst_scl", sccb_sclk, 1);
    chk("mrst_sda", sda_bus, 1);
    chk("mrst_lut", lut, 16'h4110);
    chk("mrst_done", done, 0);
    chk("mrst_ack_err", ack_err, 0);
    repeat (2) @(posedge clk);
  endtask

  task automatic random_plan(output logic any);
    any = 1'b0;
    for (int i = 0; i < 12; i++) begin
      plan[i] = {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)};
      if (plan[i] != 3'b000) any = 1'b1;
    end
  endtask

  initial begin
    logic any;
    for (int i = 0; i < 12; i++) plan[i] = 3'b000;
    // Reset defaults
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_scl", sccb_sclk, 1);
    chk("rst_sda", sda_bus, 1);
    chk("rst_lut", lut, 16'h4110);
    chk("rst_done", done, 0);
    chk("rst_ack_err", ack_err, 0);

    // Full sequence, every slot ACKed, then a long idle after done
    release_rst();
    wait_done();
    run_end(1'b0);
    repeat (10000) @(posedge clk);
    #1;
    chk("idle_violations", viol, 0);
    chk("idle_txn_count", txn, 12);

    // NACK on the second ACK of entry 3
    assert_rst(3);
    plan[3] = 3'b010;
    release_rst();
    wait_done();
    run_end(1'b1);

    // Reset during the reg_data byte of entry 5, then a randomized NACK run
    assert_rst(3);
    plan[3] = 3'b000;
    release_rst();
    mid_reset(5, 18, 26);
    random_plan(any);
    release_rst();
    wait_done();
    run_end(any);

    // Randomized reset points and NACK plans
    for (int r = 0; r < 2; r++) begin
      int tt, bb;
      tt = $urandom_range(0, 11);
      bb = $urandom_range(1, 26);
      assert_rst(2);
      for (int i = 0; i < 12; i++) plan[i] = 3'b000;
      release_rst();
      mid_reset(tt, bb, bb);
      random_plan(any);
      release_rst();
      wait_done();
      run_end(any);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
